// File: rtl/main_ctrl_fsm_pkg.sv
// Shared control encodings for the multicycle RISC-V core: opcodes, FSM states
// and the mux/ALUOp codes consumed by the ALU decoder and the datapath.
package riscv_ctrl_pkg;

    localparam int unsigned CTRL_STATE_W = 4;
    localparam int unsigned CTRL_OP_W    = 7;

    localparam logic [CTRL_OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [CTRL_OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [CTRL_OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [CTRL_OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [CTRL_OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [CTRL_OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [CTRL_OP_W-1:0] OP_LUI   = 7'b0110111;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11
    } ctrlState_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } srcA_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcB_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOp_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } resultSrc_t;

    function automatic logic isSupportedOp(input logic [CTRL_OP_W-1:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_BEQ, OP_LUI: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath /
// ALU decoder (slave).
interface main_ctrl_fsm_if #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned OP_W    = 7
);
    logic [OP_W-1:0]    op;
    logic               mem_ready;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         result_src;
    logic               adr_src;
    logic               ir_write;
    logic               pc_update;
    logic               branch;
    logic               reg_write;
    logic               mem_write;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, mem_ready,
        output alu_src_a, alu_src_b, alu_op, result_src, adr_src,
               ir_write, pc_update, branch, reg_write, mem_write,
               illegal_op, state_o
    );

    modport slave (
        output op, mem_ready,
        input  alu_src_a, alu_src_b, alu_op, result_src, adr_src,
               ir_write, pc_update, branch, reg_write, mem_write,
               illegal_op, state_o
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/execute/writeback
// and drives datapath enables, mux selects and ALUOp.
module main_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned OP_W    = 7
) (
    input  logic            clk,
    input  logic            reset,
    main_ctrl_fsm_if.master bus
);

    ctrlState_t            state;
    logic [OP_W-1:0]       opIn;
    logic [CTRL_OP_W-1:0]  opc;
    logic                  memReady;

    assign opIn     = bus.op;
    assign opc      = opIn[CTRL_OP_W-1:0];
    assign memReady = bus.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    state <= memReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opc)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_JAL:            state <= S_JAL;
                        OP_BEQ:            state <= S_BEQ;
                        OP_LUI:            state <= S_LUI;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= opc[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= memReady ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= memReady ? S_FETCH : S_MEMWRITE;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BEQ:      state <= S_FETCH;
                S_LUI:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Reset overrides the decoded state so no write can leak out while reset
    // is high, even on the cycle before the register has been cleared.
    always_comb begin
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.alu_op     = ALUOP_ADD;
        bus.result_src = RES_ALUOUT;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_update  = 1'b0;
        bus.branch     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.illegal_op = 1'b0;
        if (reset) begin
            bus.alu_src_b  = SRCB_FOUR;
            bus.result_src = RES_ALURESULT;
        end else begin
            case (state)
                S_FETCH: begin
                    bus.alu_src_b  = SRCB_FOUR;
                    bus.result_src = RES_ALURESULT;
                    bus.ir_write   = memReady;
                    bus.pc_update  = memReady;
                end
                S_DECODE: begin
                    bus.alu_src_a  = SRCA_OLDPC;
                    bus.alu_src_b  = SRCB_IMM;
                    bus.illegal_op = ~isSupportedOp(opc);
                end
                S_MEMADR: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: bus.adr_src = 1'b1;
                S_MEMWB: begin
                    bus.result_src = RES_DATA;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.adr_src   = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_EXECR: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_op    = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: bus.reg_write = 1'b1;
                S_JAL: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.pc_update = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_op    = ALUOP_SUB;
                    bus.branch    = 1'b1;
                end
                S_LUI: begin
                    bus.alu_src_a = SRCA_ZERO;
                    bus.alu_src_b = SRCB_IMM;
                end
                default: bus.illegal_op = 1'b1;
            endcase
        end
    end

    assign bus.state_o = STATE_W'(state);

endmodule
